// File: rtl/disp_scan_ctrl.sv
// Scan controller for a common-anode 7-segment bank: one BCD nibble per slot,
// with anode dead-time at the start of every slot and per-digit blink for time-edit mode.
module disp_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [3:0]                digit_code,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      dp_n,
  output logic                      frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [FW-1:0]   fcnt, fcnt_nxt;
  logic            blink_phase, phase_nxt;
  logic            dp_sel, dp_sel_nxt;
  logic [3:0]      code_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic            dp_nxt;
  logic            tick_nxt;
  logic            load;
  logic            wrap;
  logic [IW-1:0]   load_idx;
  logic [3:0]      sel_nib;
  logic            sel_blink;
  logic            sel_dp;
  logic            blank_now;

  // Outputs are computed one cycle ahead so every output is a plain register.
  // The slot counter runs 0..SCAN_DIV-1 across BLANK and SHOW; the digit
  // snapshot is taken on every BLANK entry using the blink phase that will be
  // in force for the new slot, so the phase flip lines up with digit 0.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    fcnt_nxt   = fcnt;
    phase_nxt  = blink_phase;
    dp_sel_nxt = dp_sel;
    code_nxt   = digit_code;
    an_nxt     = an_n;
    dp_nxt     = dp_n;
    tick_nxt   = 1'b0;
    load       = 1'b0;
    wrap       = 1'b0;
    load_idx   = idx;
    sel_nib    = 4'hF;
    sel_blink  = 1'b0;
    sel_dp     = 1'b0;
    blank_now  = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      code_nxt  = 4'hF;
      an_nxt    = '1;
      dp_nxt    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          load      = 1'b1;
          load_idx  = '0;
        end
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state_nxt   = SHOW;
            an_nxt      = '1;
            an_nxt[idx] = 1'b0;
            dp_nxt      = ~dp_sel;
          end
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            an_nxt    = '1;
            dp_nxt    = 1'b1;
            load      = 1'b1;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
            load_idx = idx_nxt;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          code_nxt  = 4'hF;
          an_nxt    = '1;
          dp_nxt    = 1'b1;
        end
      endcase
    end

    if (wrap) begin
      tick_nxt = 1'b1;
      if (fcnt == FRAME_LAST) begin
        fcnt_nxt  = '0;
        phase_nxt = ~blink_phase;
      end else begin
        fcnt_nxt = fcnt + 1'b1;
      end
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_idx == IW'(i)) begin
        sel_nib   = digits_in[4*i +: 4];
        sel_blink = blink_mask[i];
        sel_dp    = dp_mask[i];
      end
    end

    if (load) begin
      blank_now  = sel_blink & phase_nxt;
      code_nxt   = blank_now ? 4'hF : sel_nib;
      dp_sel_nxt = sel_dp & ~blank_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      dp_sel      <= 1'b0;
      digit_code  <= 4'hF;
      an_n        <= '1;
      dp_n        <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      fcnt        <= fcnt_nxt;
      blink_phase <= phase_nxt;
      dp_sel      <= dp_sel_nxt;
      digit_code  <= code_nxt;
      an_n        <= an_nxt;
      dp_n        <= dp_nxt;
      frame_tick  <= tick_nxt;
    end
  end

endmodule
